// File: rtl/pico_int_ctrl.sv
// Four-source interrupt controller for a KCPSM3 core: per-source pending/overrun
// cells, a small register block on the port bus, and an IDLE/ASSERT/SERVICE handshake.
module pico_int_src (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clr,
  input  logic ovr_clr,
  output logic pend,
  output logic ovr
);
  // A tick always wins over a same-cycle clear, for both pend and ovr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | tick;
      ovr  <= (ovr & ~ovr_clr) | (tick & pend);
    end
  end
endmodule

module pico_int_ctrl #(
  parameter logic [7:0] BASE = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] src_tick,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  input  logic       read_strobe,
  output logic [7:0] rd_data,
  output logic       rd_hit,
  output logic       interrupt,
  input  logic       interrupt_ack
);
  localparam int NUM_SRC = 4;

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

  state_t               state, state_n;
  logic [NUM_SRC-1:0]   pend, ovr, mask, qual;
  logic [NUM_SRC-1:0]   pend_clr, ack_clr;
  logic [2:0]           id, id_n;
  logic [2:0]           off;
  logic                 wr, rd, req, svc, ack_take, ovr_rd, eoi;

  assign rd_hit = (port_id[7:3] == BASE[7:3]);
  assign off    = port_id[2:0];
  assign wr     = write_strobe & rd_hit;
  assign rd     = read_strobe & rd_hit;
  assign qual   = pend & mask;
  assign req    = |qual;
  assign svc    = (state == S_SERVICE);
  assign ovr_rd = rd && (off == 3'd4);
  assign eoi    = wr && (off == 3'd3);
  assign ack_take = (state == S_ASSERT) && interrupt_ack;

  // Lowest qualifying index wins; 3'b100 flags a spurious acknowledge.
  always_comb begin
    id_n    = 3'b100;
    ack_clr = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (qual[i]) begin
        id_n    = 3'(i);
        ack_clr = NUM_SRC'(1) << i;
      end
    end
  end

  assign pend_clr = ((wr && off == 3'd0) ? out_port[3:0] : '0) |
                    (ack_take ? ack_clr : '0);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    pico_int_src u_src (
      .clk     (clk),
      .reset   (reset),
      .tick    (src_tick[g]),
      .clr     (pend_clr[g]),
      .ovr_clr (ovr_rd),
      .pend    (pend[g]),
      .ovr     (ovr[g])
    );
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (req)           state_n = S_ASSERT;
      S_ASSERT:  if (interrupt_ack) state_n = S_SERVICE;
      S_SERVICE: if (eoi)           state_n = S_IDLE;
      default:                      state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      interrupt <= 1'b0;
      mask      <= '0;
      id        <= '0;
    end else begin
      state     <= state_n;
      interrupt <= (state_n == S_ASSERT);
      if (wr && off == 3'd1) mask <= out_port[3:0];
      if (ack_take)          id   <= id_n;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_hit) begin
      case (off)
        3'd0:    rd_data = {4'b0, pend};
        3'd1:    rd_data = {4'b0, mask};
        3'd2:    rd_data = svc ? {1'b1, 4'b0, id} : 8'h00;
        3'd4:    rd_data = {4'b0, ovr};
        default: rd_data = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_pico_int_ctrl.sv
// Directed bench for pico_int_ctrl: register map, priority, spurious ack,
// overrun, set/clear collisions and reset during service.
module tb_pico_int_ctrl;
  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] src_tick;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic       read_strobe;
  logic [7:0] rd_data;
  logic       rd_hit;
  logic       interrupt;
  logic       interrupt_ack;

  int checks   = 0;
  int failures = 0;

  pico_int_ctrl #(.BASE(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .src_tick      (src_tick),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .out_port      (out_port),
    .read_strobe   (read_strobe),
    .rd_data       (rd_data),
    .rd_hit        (rd_hit),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    @(negedge clk);
    port_id = BASE + 8'(off); out_port = d; write_strobe = 1'b1;
    @(posedge clk); #1;
    write_strobe = 1'b0;
  endtask

  // Read with strobe: data checked combinationally, then the strobe edge retires.
  task automatic rd_chk(input string tag, input logic [2:0] off, input logic [7:0] exp);
    @(negedge clk);
    port_id = BASE + 8'(off); read_strobe = 1'b1;
    #1 chk(tag, rd_data, exp);
    @(posedge clk); #1;
    read_strobe = 1'b0;
  endtask

  task automatic tick(input logic [3:0] t);
    @(negedge clk);
    src_tick = t;
    @(posedge clk); #1;
    src_tick = 4'b0;
  endtask

  task automatic ack(input logic [3:0] t);
    @(negedge clk);
    interrupt_ack = 1'b1; src_tick = t;
    @(posedge clk); #1;
    interrupt_ack = 1'b0; src_tick = 4'b0;
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 3 && !interrupt; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, {7'b0, interrupt}, 8'h01);
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, {7'b0, interrupt}, 8'h00);
    end
  endtask

  initial begin
    reset = 1'b0; src_tick = 4'b0; port_id = 8'h00; write_strobe = 1'b0;
    out_port = 8'h00; read_strobe = 1'b0; interrupt_ack = 1'b0;

    // Combinational decode valid during reset
    #2 port_id = BASE + 8'd1;
    #1 chk("hit_in_reset", {7'b0, rd_hit}, 8'h01);
    chk("mask_in_reset", rd_data, 8'h00);
    port_id = 8'h20;
    #1 chk("miss", {7'b0, rd_hit}, 8'h00);
    chk("miss_data", rd_data, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("irq_after_reset", {7'b0, interrupt}, 8'h00);
    rd_chk("pend_rst", 3'd0, 8'h00);
    rd_chk("vec_rst", 3'd2, 8'h00);
    rd_chk("ovr_rst", 3'd4, 8'h00);
    wr(3'd5, 8'hFF);
    rd_chk("off5", 3'd5, 8'h00);
    rd_chk("off7", 3'd7, 8'h00);

    // Basic service of src1
    wr(3'd1, 8'h03);
    rd_chk("mask_03", 3'd1, 8'h03);
    tick(4'b0010);
    rd_chk("pend_src1", 3'd0, 8'h02);
    wait_irq("irq_basic");
    ack(4'b0);
    chk("irq_drop_ack", {7'b0, interrupt}, 8'h00);
    rd_chk("vec_81", 3'd2, 8'h81);
    rd_chk("pend_cleared", 3'd0, 8'h00);
    wr(3'd3, 8'h00);
    rd_chk("vec_idle", 3'd2, 8'h00);
    quiet("irq_after_eoi", 3);

    // Priority: src0 before src3
    wr(3'd1, 8'h0F);
    tick(4'b1001);
    wait_irq("irq_prio1");
    ack(4'b0);
    rd_chk("vec_80", 3'd2, 8'h80);
    rd_chk("pend_08", 3'd0, 8'h08);
    wr(3'd3, 8'h00);
    wait_irq("irq_prio2");
    ack(4'b0);
    rd_chk("vec_83", 3'd2, 8'h83);
    wr(3'd3, 8'h00);
    rd_chk("pend_prio_done", 3'd0, 8'h00);

    // Masked source, then spurious ack
    wr(3'd1, 8'h00);
    tick(4'b0100);
    rd_chk("pend_04", 3'd0, 8'h04);
    quiet("irq_masked", 3);
    wr(3'd1, 8'h04);
    wait_irq("irq_unmask");
    wr(3'd0, 8'h04);
    chk("irq_held", {7'b0, interrupt}, 8'h01);
    ack(4'b0);
    rd_chk("vec_84", 3'd2, 8'h84);
    wr(3'd3, 8'h00);
    quiet("irq_spur_done", 2);

    // Overrun
    wr(3'd1, 8'h00);
    tick(4'b0001);
    tick(4'b0001);
    rd_chk("ovr_01", 3'd4, 8'h01);
    rd_chk("ovr_00", 3'd4, 8'h00);
    @(negedge clk);
    port_id = BASE + 8'd4; read_strobe = 1'b1; src_tick = 4'b0001;
    @(posedge clk); #1;
    read_strobe = 1'b0; src_tick = 4'b0;
    rd_chk("ovr_set_wins", 3'd4, 8'h01);
    wr(3'd0, 8'h0F);
    rd_chk("pend_clr_all", 3'd0, 8'h00);

    // Collisions
    @(negedge clk);
    port_id = BASE; out_port = 8'h01; write_strobe = 1'b1; src_tick = 4'b0001;
    @(posedge clk); #1;
    write_strobe = 1'b0; src_tick = 4'b0;
    rd_chk("pend_set_wins", 3'd0, 8'h01);
    wr(3'd0, 8'h01);
    wr(3'd1, 8'h02);
    tick(4'b0010);
    wait_irq("irq_coll");
    ack(4'b0010);
    rd_chk("pend_tick_on_ack", 3'd0, 8'h02);
    rd_chk("vec_coll", 3'd2, 8'h81);
    wr(3'd3, 8'h00);
    wait_irq("irq_reassert");
    ack(4'b0);
    rd_chk("vec_coll2", 3'd2, 8'h81);
    wr(3'd3, 8'h00);

    // Reset during SERVICE
    wr(3'd1, 8'h01);
    tick(4'b0001);
    wait_irq("irq_pre_rst");
    ack(4'b0);
    rd_chk("vec_pre_rst", 3'd2, 8'h80);
    @(negedge clk);
    reset = 1'b0;
    port_id = BASE + 8'd2;
    #1 chk("vec_in_rst", rd_data, 8'h00);
    chk("irq_in_rst", {7'b0, interrupt}, 8'h00);
    port_id = BASE + 8'd1;
    #1 chk("mask_in_rst", rd_data, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    wr(3'd3, 8'h00);
    rd_chk("vec_post_rst", 3'd2, 8'h00);
    ack(4'b0);
    rd_chk("vec_ack_idle", 3'd2, 8'h00);
    quiet("irq_post_rst", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pico_int_ctrl.md
PICO_INT_CTRL -- requirements
Module: pico_int_ctrl

Interface
REQ-001 SHALL have parameter BASE, default 8'h10, the port_id base address of the register block; BASE[2:0] is 3'b000.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port src_tick, input, 4, one-cycle event pulses from sources 0..3.
REQ-005 SHALL have port port_id, input, 8, the KCPSM3 port address.
REQ-006 SHALL have port write_strobe, input, 1, the KCPSM3 output strobe.
REQ-007 SHALL have port out_port, input, 8, the KCPSM3 write data.
REQ-008 SHALL have port read_strobe, input, 1, the KCPSM3 input strobe.
REQ-009 SHALL have port rd_data, output, 8, register read data, combinational from port_id.
REQ-010 SHALL have port rd_hit, output, 1, high when port_id[7:3] == BASE[7:3]; the top-level in_port mux uses it.
REQ-011 SHALL have port interrupt, output, 1, registered, to KCPSM3 interrupt.
REQ-012 SHALL have port interrupt_ack, input, 1, from KCPSM3.

Function
REQ-013 SHALL decode the register map (offset = port_id[2:0]; write = write_strobe & hit; read = read_strobe & hit) as follows:
- 0 PEND: read pend[3:0]; write-1-to-clear.
- 1 MASK: read/write mask[3:0]; out_port[7:4] ignored.
- 2 VECTOR: read {svc, 4'b0, id[2:0]}.
- 3 EOI: write any value ends service.
- 4 OVR: read ovr[3:0]; read clears.
- Offsets 5-7: read 8'h00, writes ignored.
REQ-014 SHALL set pend[i] on src_tick[i]; if pend[i] was already 1, it SHALL also set ovr[i].
REQ-015 SHALL give set priority over clear when src_tick[i] and a PEND write-1 hit the same bit in one cycle; this applies also to ovr set versus the OVR read-clear.
REQ-016 SHALL compute req = |(pend & mask).
REQ-017 SHALL implement a 3-state FSM:
- IDLE: if req, go to ASSERT next cycle, with interrupt = 1.
- ASSERT: interrupt held 1 regardless of later masking or clearing. On interrupt_ack, go to SERVICE and set interrupt = 0 next cycle.
- SERVICE: on an EOI write, go to IDLE.
REQ-018 SHALL, in the ack cycle, latch id = lowest index i with pend[i] & mask[i] (0 highest priority) and clear that pend bit; if none qualifies, it SHALL latch id = 3'b100 (spurious) and clear nothing.
REQ-019 SHALL drive svc = 1 only in SERVICE; VECTOR reads 8'h00 outside SERVICE.
REQ-020 SHALL ignore interrupt_ack in IDLE or SERVICE and ignore EOI writes outside SERVICE.
REQ-021 SHALL let ticks in SERVICE (including the serviced source) set pend normally; they are taken after EOI, and IDLE re-asserts one cycle later if req.
REQ-022 SHALL give a tick arriving on the ack cycle for the serviced source priority over the clear, so pend stays 1.
REQ-023 SHALL hold interrupt low from reset release for at least one cycle; minimum ASSERT duration is governed only by ack.

Reset
REQ-024 SHALL, on reset low, asynchronously set pend = 0, mask = 0, ovr = 0, id = 0, state = IDLE, interrupt = 0.
REQ-025 SHALL, on reset mid-ASSERT or mid-SERVICE, abandon the service with no EOI required.
REQ-026 SHALL leave rd_data and rd_hit purely combinational, valid in and out of reset.

Verification
REQ-027 Basic service: MASK = 8'h03, tick src1 -> PEND reads 8'h02; interrupt high within 2 cycles; ack -> VECTOR 8'h81, PEND 8'h00; EOI -> IDLE, interrupt stays 0.
REQ-028 Priority: MASK = 8'h0F, ticks src3 and src0 same cycle -> first ack VECTOR 8'h80, after EOI second interrupt, ack VECTOR 8'h83.
REQ-029 Masked and spurious: mask 0, tick src2 -> PEND 8'h04, interrupt stays 0. Set MASK 8'h04, then clear PEND bit2 during ASSERT -> ack VECTOR 8'h84.
REQ-030 Overrun: two src0 ticks without service -> OVR reads 8'h01, then 8'h00 on the next read; tick coincident with OVR read -> reads 8'h01 afterwards.
REQ-031 Collisions: PEND write 8'h01 same cycle as src0 tick -> PEND bit0 = 1. Ack and src1 tick together while servicing src1 -> PEND 8'h02 after ack.
REQ-032 Reset: assert reset during SERVICE -> interrupt 0, VECTOR 8'h00, MASK 8'h00 immediately; EOI write after release has no effect.
